// File: rtl/imm_pkg.sv
// Shared types and constants for the immediate-load sequencer.
package imm_pkg;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_DRIVE_LO = 2'd1,
      ST_EXT_WAIT = 2'd2,
      ST_DRIVE_HI = 2'd3
   } state_e;

   localparam logic [1:0] OP_NOP  = 2'b00;
   localparam logic [1:0] OP_LDA  = 2'b01;
   localparam logic [1:0] OP_LDB  = 2'b10;
   localparam logic [1:0] OP_LDOP = 2'b11;

   localparam logic [1:0] EN_IMM = 2'b10;

   localparam logic [1:0] MARK_LO = 2'b00;
   localparam logic [1:0] MARK_HI = 2'b01;

   // Both nibbles of the control word carry the same marker and op.
   function automatic logic [7:0] ctrl_word(input logic [1:0] mark, input logic [1:0] op);
      return {mark, op, mark, op};
   endfunction

endpackage

// File: rtl/imm_tmo_cnt.sv
// Timeout counter for the second immediate beat; expire is high once the count reaches TMO.
module imm_tmo_cnt #(
   parameter int TMO = 15
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic inc,
   output logic expire
);

   localparam int CW = $clog2(TMO + 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (inc) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expire = (cnt_q == CW'(TMO));

endmodule

// File: rtl/imm_seq.sv
// Immediate-load sequencer: drives one or two immediate nibbles onto a shared bus
// with matching control words, with an optional two-beat extended form.
module imm_seq
   import imm_pkg::*;
#(
   parameter int DW     = 4,
   parameter int IW     = 8,
   parameter int EXT_EN = 1,
   parameter int TMO    = 15
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [1:0]    en,
   input  logic [IW-1:0] instr,
   input  logic          in_valid,
   output logic          in_ready,
   inout  wire  [DW-1:0] bus,
   output logic [7:0]    ctrl,
   output logic [DW-1:0] imm,
   output logic          done,
   output logic          err
);

   state_e        state_q, state_d;
   logic [1:0]    op_q, op_d;
   logic [DW-1:0] lo_q, lo_d;
   logic [DW-1:0] hi_q, hi_d;
   logic          ext_q, ext_d;
   logic [7:0]    ctrl_q, ctrl_d;
   logic [DW-1:0] imm_q, imm_d;
   logic          done_q, done_d;
   logic          err_q, err_d;
   logic          drive_q, drive_d;

   logic          accept;
   logic          tmo_clr;
   logic          tmo_inc;
   logic          tmo_expire;
   logic [1:0]    op_in;
   logic          ext_in;
   logic [DW-1:0] nib_in;
   logic          unused_instr;

   assign op_in        = instr[6:5];
   assign ext_in       = instr[4];
   assign nib_in       = instr[DW-1:0];
   assign unused_instr = ^instr;

   assign in_ready = (state_q == ST_IDLE) || (state_q == ST_EXT_WAIT);
   assign accept   = in_valid && in_ready;

   imm_tmo_cnt #(.TMO(TMO)) u_tmo (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr    (tmo_clr),
      .inc    (tmo_inc),
      .expire (tmo_expire)
   );

   // Outputs are computed for the state being entered so they appear registered in that state.
   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      lo_d    = lo_q;
      hi_d    = hi_q;
      ext_d   = ext_q;
      ctrl_d  = '0;
      imm_d   = '0;
      done_d  = 1'b0;
      err_d   = 1'b0;
      drive_d = 1'b0;
      tmo_clr = 1'b0;
      tmo_inc = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (accept && en == EN_IMM) begin
               if (op_in == OP_NOP) begin
                  done_d = 1'b1;
               end else if (ext_in && EXT_EN != 0) begin
                  state_d = ST_EXT_WAIT;
                  op_d    = op_in;
                  lo_d    = nib_in;
                  tmo_clr = 1'b1;
               end else begin
                  state_d = ST_DRIVE_LO;
                  op_d    = op_in;
                  lo_d    = nib_in;
                  ext_d   = 1'b0;
                  ctrl_d  = ctrl_word(MARK_LO, op_in);
                  imm_d   = nib_in;
                  drive_d = 1'b1;
                  done_d  = 1'b1;
               end
            end
         end
         ST_EXT_WAIT: begin
            // A second beat in the same cycle as expiry still wins.
            if (accept) begin
               if (en == EN_IMM) begin
                  state_d = ST_DRIVE_LO;
                  hi_d    = nib_in;
                  ext_d   = 1'b1;
                  ctrl_d  = ctrl_word(MARK_LO, op_q);
                  imm_d   = lo_q;
                  drive_d = 1'b1;
               end else begin
                  state_d = ST_IDLE;
                  err_d   = 1'b1;
               end
            end else if (tmo_expire) begin
               state_d = ST_IDLE;
               err_d   = 1'b1;
            end else begin
               tmo_inc = 1'b1;
            end
         end
         ST_DRIVE_LO: begin
            if (ext_q) begin
               state_d = ST_DRIVE_HI;
               ctrl_d  = ctrl_word(MARK_HI, op_q);
               imm_d   = hi_q;
               drive_d = 1'b1;
               done_d  = 1'b1;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_DRIVE_HI: begin
            state_d = ST_IDLE;
            ext_d   = 1'b0;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         op_q    <= '0;
         lo_q    <= '0;
         hi_q    <= '0;
         ext_q   <= 1'b0;
         ctrl_q  <= '0;
         imm_q   <= '0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         drive_q <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         lo_q    <= lo_d;
         hi_q    <= hi_d;
         ext_q   <= ext_d;
         ctrl_q  <= ctrl_d;
         imm_q   <= imm_d;
         done_q  <= done_d;
         err_q   <= err_d;
         drive_q <= drive_d;
      end
   end

   assign bus  = drive_q ? imm_q : {DW{1'bz}};
   assign ctrl = ctrl_q;
   assign imm  = imm_q;
   assign done = done_q;
   assign err  = err_q;

endmodule
